// File: rtl/record_timer.sv
// Record/playback elapsed-time controller: tracks seconds while recording or playing,
// remembers the recorded length and drives the two-digit time display (63 = blank).
//
// state | meaning
// IDLE  | nothing running, display blank, stored length kept
// REC   | recording, seconds count up toward the length limit
// PLAY  | playing back, seconds count up toward the stored length
// PAUSE | counters frozen, mode holds which of REC/PLAY to resume
module record_timer #(
   parameter int TICKS_PER_SEC = 12000000,
   parameter int MAX_SEC       = 32
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rec,
   input  logic       i_play,
   input  logic       i_pause,
   input  logic       i_stop,
   output logic [5:0] o_time,
   output logic [5:0] o_len,
   output logic [1:0] o_state,
   output logic       o_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REC   = 2'd1,
      PLAY  = 2'd2,
      PAUSE = 2'd3
   } state_t;

   localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
   localparam logic [5:0] SEC_LIMIT = 6'(MAX_SEC);
   localparam logic [5:0] BLANK = 6'd63;
   localparam logic MODE_REC = 1'b0;
   localparam logic MODE_PLAY = 1'b1;

   state_t state, state_n;
   logic [TW-1:0] tick, tick_n, tick_adv;
   logic [5:0] sec, sec_n, sec_inc, sec_adv;
   logic [5:0] len, len_n;
   logic [5:0] time_q, time_n;
   logic done, done_n;
   logic mode, mode_n;
   logic wrap;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         tick   <= '0;
         sec    <= '0;
         len    <= '0;
         time_q <= BLANK;
         done   <= 1'b0;
         mode   <= MODE_REC;
      end else begin
         state  <= state_n;
         tick   <= tick_n;
         sec    <= sec_n;
         len    <= len_n;
         time_q <= time_n;
         done   <= done_n;
         mode   <= mode_n;
      end
   end

   always_comb begin
      state_n  = state;
      tick_n   = tick;
      sec_n    = sec;
      len_n    = len;
      done_n   = 1'b0;
      mode_n   = mode;
      wrap     = (tick == TICK_LAST);
      sec_inc  = sec + 6'd1;
      tick_adv = wrap ? '0 : tick + TW'(1);
      sec_adv  = wrap ? sec_inc : sec;

      case (state)
         IDLE: begin
            if (i_rec) begin
               state_n = REC;
               tick_n  = '0;
               sec_n   = '0;
            end else if (i_play && (len != 6'd0)) begin
               state_n = PLAY;
               tick_n  = '0;
               sec_n   = '0;
            end
         end
         REC: begin
            tick_n = tick_adv;
            sec_n  = sec_adv;
            // A stop on the limit edge still records the full limit, without done.
            if (i_stop) begin
               state_n = IDLE;
               len_n   = (wrap && (sec_inc == SEC_LIMIT)) ? SEC_LIMIT : sec;
            end else if (wrap && (sec_inc == SEC_LIMIT)) begin
               state_n = IDLE;
               len_n   = SEC_LIMIT;
               done_n  = 1'b1;
            end else if (i_pause) begin
               state_n = PAUSE;
               mode_n  = MODE_REC;
               tick_n  = tick;
               sec_n   = sec;
            end
         end
         PLAY: begin
            tick_n = tick_adv;
            sec_n  = sec_adv;
            if (i_stop) begin
               state_n = IDLE;
            end else if (wrap && (sec_inc == len)) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else if (i_pause) begin
               state_n = PAUSE;
               mode_n  = MODE_PLAY;
               tick_n  = tick;
               sec_n   = sec;
            end
         end
         PAUSE: begin
            if (i_stop) begin
               state_n = IDLE;
               if (mode == MODE_REC) len_n = sec;
            end else if (i_pause) begin
               state_n = (mode == MODE_PLAY) ? PLAY : REC;
            end
         end
         default: state_n = IDLE;
      endcase

      time_n = (state_n == IDLE) ? BLANK : sec_n;
   end

   always_comb begin
      o_state = state;
      o_time  = time_q;
      o_len   = len;
      o_done  = done;
   end

endmodule

// File: tb/tb_record_timer.sv
// Bench for record_timer (4 ticks/s, 5 s limit): expected output changes are queued
// with the cycle they must appear on; a monitor pops one per observed output change.
module tb_record_timer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rec, play, pause, stop;
   logic [5:0] time_v, len_v;
   logic [1:0] state_v;
   logic       done_v;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         at;
      logic [1:0] st;
      logic [5:0] tm;
      logic [5:0] ln;
      logic       dn;
   } exp_t;

   exp_t q[$];

   record_timer #(.TICKS_PER_SEC(4), .MAX_SEC(5)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_rec   (rec),
      .i_play  (play),
      .i_pause (pause),
      .i_stop  (stop),
      .o_time  (time_v),
      .o_len   (len_v),
      .o_state (state_v),
      .o_done  (done_v)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_at(input int at, input logic [1:0] st, input logic [5:0] tm,
                            input logic [5:0] ln, input logic dn);
      exp_t e;
      e.at = at; e.st = st; e.tm = tm; e.ln = ln; e.dn = dn;
      q.push_back(e);
   endtask

   // sel = {stop, pause, play, rec}; driven at the negedge where cyc == c
   task automatic pulse_at(input int c, input logic [3:0] sel);
      while (cyc < c) @(negedge clk);
      checks++;
      if (cyc != c) begin
         errors++;
         $display("FAIL schedule: at cycle %0d, required %0d", cyc, c);
      end
      {stop, pause, play, rec} = sel;
      @(negedge clk);
      {stop, pause, play, rec} = 4'b0000;
   endtask

   task automatic reset_at(input int c);
      while (cyc < c) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [14:0] prev;
   logic        first = 1'b1;

   always @(negedge clk) begin
      logic [14:0] snap;
      exp_t e;
      snap = {state_v, time_v, len_v, done_v};
      if (cyc >= 1) begin
         if (first || (snap !== prev)) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: cycle %0d state=%0d time=%0d len=%0d done=%0d",
                        cyc, state_v, time_v, len_v, done_v);
            end else begin
               e = q.pop_front();
               if (e.at != cyc || snap !== {e.st, e.tm, e.ln, e.dn}) begin
                  errors++;
                  $display("FAIL output_change: got cycle %0d st=%0d tm=%0d ln=%0d dn=%0d, required cycle %0d st=%0d tm=%0d ln=%0d dn=%0d",
                           cyc, state_v, time_v, len_v, done_v, e.at, e.st, e.tm, e.ln, e.dn);
               end
            end
            first = 1'b0;
         end else if (q.size() != 0 && q[0].at < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_change: nothing by cycle %0d, required at %0d st=%0d tm=%0d ln=%0d dn=%0d",
                     cyc, e.at, e.st, e.tm, e.ln, e.dn);
         end
      end
      prev = snap;
   end

   initial begin
      int c, p, guard;
      rst_n = 1'b0;
      {stop, pause, play, rec} = 4'b0000;

      // reset, idle, ignored play/pause/stop with empty length
      expect_at(1, 2'd0, 6'd63, 6'd0, 1'b0);
      while (cyc < 3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      pulse_at(cyc, 4'b0010);
      pulse_at(cyc + 1, 4'b0100);
      pulse_at(cyc + 1, 4'b1000);

      // full recording to the limit; play inside REC is ignored
      c = cyc + 2;
      expect_at(c + 1, 2'd1, 6'd0, 6'd0, 1'b0);
      for (int k = 1; k <= 4; k++) expect_at(c + 1 + 4 * k, 2'd1, 6'(k), 6'd0, 1'b0);
      expect_at(c + 21, 2'd0, 6'd63, 6'd5, 1'b1);
      expect_at(c + 22, 2'd0, 6'd63, 6'd5, 1'b0);
      pulse_at(c, 4'b0001);
      pulse_at(c + 3, 4'b0010);

      // stop at sec=2, then playback to the stored length
      c = c + 26;
      expect_at(c + 1, 2'd1, 6'd0, 6'd5, 1'b0);
      expect_at(c + 5, 2'd1, 6'd1, 6'd5, 1'b0);
      expect_at(c + 9, 2'd1, 6'd2, 6'd5, 1'b0);
      expect_at(c + 10, 2'd0, 6'd63, 6'd2, 1'b0);
      p = c + 12;
      expect_at(p + 1, 2'd2, 6'd0, 6'd2, 1'b0);
      expect_at(p + 5, 2'd2, 6'd1, 6'd2, 1'b0);
      expect_at(p + 9, 2'd0, 6'd63, 6'd2, 1'b1);
      expect_at(p + 10, 2'd0, 6'd63, 6'd2, 1'b0);
      pulse_at(c, 4'b0001);
      pulse_at(c + 9, 4'b1000);
      pulse_at(p, 4'b0010);

      // pause at sec=1/tick=2, long hold, resume, stop at sec=3
      c = p + 14;
      expect_at(c + 1, 2'd1, 6'd0, 6'd2, 1'b0);
      expect_at(c + 5, 2'd1, 6'd1, 6'd2, 1'b0);
      expect_at(c + 8, 2'd3, 6'd1, 6'd2, 1'b0);
      expect_at(c + 59, 2'd1, 6'd1, 6'd2, 1'b0);
      expect_at(c + 61, 2'd1, 6'd2, 6'd2, 1'b0);
      expect_at(c + 65, 2'd1, 6'd3, 6'd2, 1'b0);
      expect_at(c + 66, 2'd0, 6'd63, 6'd3, 1'b0);
      pulse_at(c, 4'b0001);
      pulse_at(c + 7, 4'b0100);
      pulse_at(c + 20, 4'b0001);
      pulse_at(c + 30, 4'b0010);
      pulse_at(c + 58, 4'b0100);
      pulse_at(c + 65, 4'b1000);

      // rec+play together, then pause+stop together in PLAY
      c = c + 70;
      expect_at(c + 1, 2'd1, 6'd0, 6'd3, 1'b0);
      expect_at(c + 5, 2'd1, 6'd1, 6'd3, 1'b0);
      expect_at(c + 7, 2'd0, 6'd63, 6'd1, 1'b0);
      p = c + 9;
      expect_at(p + 1, 2'd2, 6'd0, 6'd1, 1'b0);
      expect_at(p + 3, 2'd0, 6'd63, 6'd1, 1'b0);
      pulse_at(c, 4'b0011);
      pulse_at(c + 6, 4'b1000);
      pulse_at(p, 4'b0010);
      pulse_at(p + 2, 4'b1100);

      // reset during paused recording at sec=3 clears everything
      c = p + 6;
      expect_at(c + 1, 2'd1, 6'd0, 6'd1, 1'b0);
      for (int k = 1; k <= 3; k++) expect_at(c + 1 + 4 * k, 2'd1, 6'(k), 6'd1, 1'b0);
      expect_at(c + 15, 2'd3, 6'd3, 6'd1, 1'b0);
      expect_at(c + 18, 2'd0, 6'd63, 6'd0, 1'b0);
      pulse_at(c, 4'b0001);
      pulse_at(c + 14, 4'b0100);
      reset_at(c + 17);
      pulse_at(c + 20, 4'b0010);

      // stop on the very edge the limit is reached: full length, no done
      c = c + 23;
      expect_at(c + 1, 2'd1, 6'd0, 6'd0, 1'b0);
      for (int k = 1; k <= 4; k++) expect_at(c + 1 + 4 * k, 2'd1, 6'(k), 6'd0, 1'b0);
      expect_at(c + 21, 2'd0, 6'd63, 6'd5, 1'b0);
      pulse_at(c, 4'b0001);
      pulse_at(c + 20, 4'b1000);

      guard = 0;
      while (q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations: %0d still queued, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
